// File: rtl/sprite_motion_sequencer_if.sv
// Sprite sequencer bus: scan control, BRAM read port, host write port and the arbitrated BRAM write port.
// The master modport is the sequencer's view; the slave modport is the surrounding system's view.
interface sprite_motion_sequencer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [8:0]  sprite_index;
  logic [35:0] sprite_y_height;
  logic [35:0] sprite_x_width;
  logic [35:0] sprite_velocity;
  logic [8:0]  h_index;
  logic [35:0] h_y_height;
  logic [35:0] h_x_width;
  logic [35:0] h_addr;
  logic [35:0] h_velocity;
  logic        h_y_height_en;
  logic        h_x_width_en;
  logic        h_addr_en;
  logic        h_velocity_en;
  logic [8:0]  w_index;
  logic [35:0] w_sprite_y_height;
  logic [35:0] w_sprite_x_width;
  logic [35:0] w_sprite_addr;
  logic [35:0] w_sprite_velocity;
  logic        w_sprite_y_height_en;
  logic        w_sprite_x_width_en;
  logic        w_sprite_addr_en;
  logic        w_sprite_velocity_en;

  modport master (
    input  start, sprite_y_height, sprite_x_width, sprite_velocity,
    input  h_index, h_y_height, h_x_width, h_addr, h_velocity,
    input  h_y_height_en, h_x_width_en, h_addr_en, h_velocity_en,
    output busy, done, sprite_index,
    output w_index, w_sprite_y_height, w_sprite_x_width, w_sprite_addr, w_sprite_velocity,
    output w_sprite_y_height_en, w_sprite_x_width_en, w_sprite_addr_en, w_sprite_velocity_en
  );

  modport slave (
    output start, sprite_y_height, sprite_x_width, sprite_velocity,
    output h_index, h_y_height, h_x_width, h_addr, h_velocity,
    output h_y_height_en, h_x_width_en, h_addr_en, h_velocity_en,
    input  busy, done, sprite_index,
    input  w_index, w_sprite_y_height, w_sprite_x_width, w_sprite_addr, w_sprite_velocity,
    input  w_sprite_y_height_en, w_sprite_x_width_en, w_sprite_addr_en, w_sprite_velocity_en
  );
endinterface

// File: rtl/sprite_motion_sequencer.sv
// Per-frame sprite motion engine: walks every sprite, integrates velocity, bounces off screen bounds,
// and owns the attribute BRAM write port with host writes taking priority.
module sprite_motion_sequencer #(
  parameter int NUM_SPRITES = 512,
  parameter int TILE_PX     = 16,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 1280,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 720
) (
  input logic                        clk_draw,
  input logic                        rst_n,
  sprite_motion_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CALC = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  typedef struct packed {
    logic [15:0] pos;
    logic [17:0] vel;
    logic        bounce;
  } axis_t;

  localparam logic [8:0]         LAST_IDX = 9'(NUM_SPRITES - 1);
  localparam logic [11:0]        TILE_SUB = 12'(TILE_PX * 16);
  localparam logic signed [21:0] X_LO     = 22'(X_MIN * 16);
  localparam logic signed [21:0] X_HI     = 22'(X_MAX * 16);
  localparam logic signed [21:0] Y_LO     = 22'(Y_MIN * 16);
  localparam logic signed [21:0] Y_HI     = 22'(Y_MAX * 16);

  // Negation saturates because +131072 is not representable in 18-bit two's complement.
  function automatic logic [17:0] neg_sat(input logic [17:0] v);
    logic [17:0] r;
    if (v == 18'h20000) begin
      r = 18'h1ffff;
    end else begin
      r = 18'd0 - v;
    end
    return r;
  endfunction

  function automatic axis_t step_axis(input logic [15:0] p, input logic [17:0] v, input logic [7:0] size,
                                      input logic signed [21:0] lo, input logic signed [21:0] hi);
    axis_t r;
    logic signed [21:0] s;
    logic signed [21:0] ext;
    s   = $signed({6'd0, p}) + $signed({{4{v[17]}}, v});
    ext = $signed({2'b00, {12'd0, size} * {8'd0, TILE_SUB}});
    if (s < lo) begin
      r.pos    = lo[15:0];
      r.vel    = neg_sat(v);
      r.bounce = 1'b1;
    end else if (s + ext > hi) begin
      // A sprite wider than the playfield cannot fit anywhere; pin it to the low edge.
      if (ext >= hi - lo) begin
        r.pos = lo[15:0];
      end else begin
        r.pos = 16'(hi - ext);
      end
      r.vel    = neg_sat(v);
      r.bounce = 1'b1;
    end else begin
      r.pos    = s[15:0];
      r.vel    = v;
      r.bounce = 1'b0;
    end
    return r;
  endfunction

  state_t      state_r, state_s;
  logic [8:0]  cnt_r, cnt_s;
  logic        cancel_r, cancel_s;
  logic        busy_r, done_r;
  logic [35:0] new_y_r, new_x_r, new_vel_r;
  logic        bounce_r;
  logic        host_wr_s, hit_s, last_s, seq_wr_s;
  axis_t       ax_s, ay_s;

  assign host_wr_s = bus.h_y_height_en | bus.h_x_width_en | bus.h_addr_en | bus.h_velocity_en;
  assign hit_s     = host_wr_s && (bus.h_index == cnt_r);
  assign last_s    = (cnt_r == LAST_IDX);
  assign seq_wr_s  = (state_r == S_WR) && !host_wr_s && !cancel_r;

  assign ax_s = step_axis(bus.sprite_x_width[15:0], bus.sprite_velocity[35:18],
                          bus.sprite_x_width[31:24], X_LO, X_HI);
  assign ay_s = step_axis(bus.sprite_y_height[15:0], bus.sprite_velocity[17:0],
                          bus.sprite_y_height[31:24], Y_LO, Y_HI);

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.sprite_index = cnt_r;

  // Next-state, counter and hazard-cancel logic for the scan FSM.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    cancel_s = cancel_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_s = S_RD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD: begin
        cancel_s = hit_s;
        state_s  = S_CALC;
      end
      S_CALC: begin
        cancel_s = cancel_r | hit_s;
        state_s  = S_WR;
      end
      S_WR: begin
        cancel_s = cancel_r | hit_s;
        if (host_wr_s) begin
          state_s = S_WR;
        end else if (last_s) begin
          cnt_s   = cnt_r + 9'd1;
          state_s = S_FIN;
        end else begin
          cnt_s   = cnt_r + 9'd1;
          state_s = S_RD;
        end
      end
      S_FIN: begin
        cnt_s   = 9'd0;
        state_s = S_IDLE;
      end
      default: begin
        cnt_s   = 9'd0;
        state_s = S_IDLE;
      end
    endcase
  end

  // Control registers; busy and done are registered from the next state.
  always_ff @(posedge clk_draw) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      cnt_r    <= 9'd0;
      cancel_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      cancel_r <= cancel_s;
      busy_r   <= (state_s == S_RD) || (state_s == S_CALC) || (state_s == S_WR);
      done_r   <= (state_s == S_FIN);
    end
  end

  // Writeback data captured while the BRAM read data is valid.
  always_ff @(posedge clk_draw) begin
    if (!rst_n) begin
      new_y_r   <= 36'd0;
      new_x_r   <= 36'd0;
      new_vel_r <= 36'd0;
      bounce_r  <= 1'b0;
    end else if (state_r == S_CALC) begin
      new_y_r   <= {bus.sprite_y_height[35:16], ay_s.pos};
      new_x_r   <= {bus.sprite_x_width[35:16], ax_s.pos};
      new_vel_r <= {ax_s.vel, ay_s.vel};
      bounce_r  <= ax_s.bounce | ay_s.bounce;
    end
  end

  // Write-port arbitration: any host enable takes the port for that cycle.
  always_comb begin
    if (host_wr_s) begin
      bus.w_index              = bus.h_index;
      bus.w_sprite_y_height    = bus.h_y_height;
      bus.w_sprite_x_width     = bus.h_x_width;
      bus.w_sprite_addr        = bus.h_addr;
      bus.w_sprite_velocity    = bus.h_velocity;
      bus.w_sprite_y_height_en = bus.h_y_height_en;
      bus.w_sprite_x_width_en  = bus.h_x_width_en;
      bus.w_sprite_addr_en     = bus.h_addr_en;
      bus.w_sprite_velocity_en = bus.h_velocity_en;
    end else begin
      bus.w_index              = cnt_r;
      bus.w_sprite_y_height    = new_y_r;
      bus.w_sprite_x_width     = new_x_r;
      bus.w_sprite_addr        = 36'd0;
      bus.w_sprite_velocity    = new_vel_r;
      bus.w_sprite_y_height_en = seq_wr_s;
      bus.w_sprite_x_width_en  = seq_wr_s;
      bus.w_sprite_addr_en     = 1'b0;
      bus.w_sprite_velocity_en = seq_wr_s & bounce_r;
    end
  end

endmodule

// File: tb/tb_sprite_motion_sequencer.sv
// Randomized self-checking bench: behavioural BRAM, host loader and a per-sprite motion reference model.
module tb_sprite_motion_sequencer;
  localparam int N = 512;

  logic clk_draw = 1'b0;
  logic rst_n;
  sprite_motion_sequencer_if bus();

  sprite_motion_sequencer #(
    .NUM_SPRITES(N), .TILE_PX(16), .X_MIN(0), .X_MAX(1280), .Y_MIN(0), .Y_MAX(720)
  ) dut (
    .clk_draw(clk_draw),
    .rst_n   (rst_n),
    .bus     (bus.master)
  );

  always #5 clk_draw = ~clk_draw;

  logic [35:0] mem_y[N], mem_x[N], mem_v[N], mem_a[N];
  logic [35:0] init_y[N], init_x[N], init_v[N];
  logic [35:0] exp_y[N], exp_x[N], exp_v[N];
  bit          exp_ve[N], exp_wr[N];
  bit          seen_xy[N], seen_ve[N];
  int          edge_cnt, seq_en_cnt, addr_en_cnt, wr5_edge;
  bit          clr_req;
  int          pass_cnt, check_cnt;

  // Behavioural BRAM (1-cycle read latency) plus a monitor of writes.
  always @(posedge clk_draw) begin
    edge_cnt            <= edge_cnt + 1;
    bus.sprite_y_height <= mem_y[bus.sprite_index];
    bus.sprite_x_width  <= mem_x[bus.sprite_index];
    bus.sprite_velocity <= mem_v[bus.sprite_index];
    if (bus.w_sprite_y_height_en) mem_y[bus.w_index] <= bus.w_sprite_y_height;
    if (bus.w_sprite_x_width_en)  mem_x[bus.w_index] <= bus.w_sprite_x_width;
    if (bus.w_sprite_velocity_en) mem_v[bus.w_index] <= bus.w_sprite_velocity;
    if (bus.w_sprite_addr_en)     mem_a[bus.w_index] <= bus.w_sprite_addr;
    if (clr_req) begin
      for (int i = 0; i < N; i++) begin
        seen_xy[i] <= 1'b0;
        seen_ve[i] <= 1'b0;
      end
      seq_en_cnt  <= 0;
      addr_en_cnt <= 0;
      wr5_edge    <= -1;
    end else begin
      if (bus.w_sprite_y_height_en) begin
        seen_xy[bus.w_index] <= 1'b1;
        seq_en_cnt           <= seq_en_cnt + 1;
        if (bus.w_index == 9'd5) wr5_edge <= edge_cnt;
      end
      if (bus.w_sprite_velocity_en) seen_ve[bus.w_index] <= 1'b1;
      if (bus.w_sprite_addr_en) addr_en_cnt <= addr_en_cnt + 1;
    end
  end

  function automatic int sx18(input logic [17:0] v);
    return v[17] ? int'(v) - 262144 : int'(v);
  endfunction

  function automatic void ref_axis(input int p, input int v, input int size, input int lo, input int hi,
                                   output int np, output int nv, output bit b);
    int s;
    int ext;
    s   = p + v;
    ext = size * 256;
    np  = s;
    nv  = v;
    b   = 1'b0;
    if (s < lo || s + ext > hi) begin
      b  = 1'b1;
      nv = (v == -131072) ? 131071 : -v;
      np = (s < lo || ext >= hi - lo) ? lo : hi - ext;
    end
  endfunction

  function automatic void ref_sprite(input logic [35:0] y, input logic [35:0] x, input logic [35:0] v,
                                     output logic [35:0] ny, output logic [35:0] nx,
                                     output logic [35:0] nv, output bit be);
    int py, vy, px, vx;
    bit by, bx;
    ref_axis(int'(y[15:0]), sx18(v[17:0]), int'(y[31:24]), 0, 720 * 16, py, vy, by);
    ref_axis(int'(x[15:0]), sx18(v[35:18]), int'(x[31:24]), 0, 1280 * 16, px, vx, bx);
    ny = {y[35:16], 16'(py)};
    nx = {x[35:16], 16'(px)};
    nv = {18'(vx), 18'(vy)};
    be = bx | by;
  endfunction

  function automatic logic [17:0] rnd_vel();
    logic [17:0] t;
    t = 18'($urandom_range(0, 1023));
    if ($urandom_range(0, 7) == 0) t = 18'($urandom);
    else t = t - 18'd512;
    return t;
  endfunction

  task automatic gen_random();
    for (int i = 0; i < N; i++) begin
      init_y[i] = {4'($urandom), 8'($urandom_range(0, 6)), 8'($urandom), 12'($urandom_range(0, 800)), 4'($urandom)};
      init_x[i] = {4'($urandom), 8'($urandom_range(0, 6)), 8'($urandom), 12'($urandom_range(0, 1400)), 4'($urandom)};
      init_v[i] = {rnd_vel(), rnd_vel()};
    end
  endtask

  task automatic model_all();
    bit be;
    for (int i = 0; i < N; i++) begin
      ref_sprite(init_y[i], init_x[i], init_v[i], exp_y[i], exp_x[i], exp_v[i], be);
      exp_ve[i] = be;
      exp_wr[i] = 1'b1;
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++) begin
      bus.h_index = 9'(i);
      bus.h_y_height = init_y[i];
      bus.h_x_width = init_x[i];
      bus.h_velocity = init_v[i];
      bus.h_y_height_en = 1'b1;
      bus.h_x_width_en = 1'b1;
      bus.h_velocity_en = 1'b1;
      @(negedge clk_draw);
    end
    bus.h_y_height_en = 1'b0;
    bus.h_x_width_en = 1'b0;
    bus.h_velocity_en = 1'b0;
    clr_req = 1'b1;
    @(negedge clk_draw);
    clr_req = 1'b0;
  endtask

  task automatic run_scan(input int ev_at, input logic [8:0] ev_idx, input logic [35:0] ev_val,
                          input int restart_at, output int lat, output int e0);
    @(negedge clk_draw);
    bus.start = 1'b1;
    @(negedge clk_draw);
    bus.start = 1'b0;
    e0 = edge_cnt;
    lat = -1;
    for (int k = 0; k < 2000; k++) begin
      if (bus.done === 1'b1) begin
        lat = k + 1;
        break;
      end
      bus.start = (k == restart_at);
      if (k == ev_at) begin
        bus.h_index = ev_idx;
        bus.h_x_width = ev_val;
        bus.h_x_width_en = 1'b1;
        #1;
        check_cnt++;
        if (bus.w_index !== ev_idx || bus.w_sprite_x_width !== ev_val ||
            bus.w_sprite_x_width_en !== 1'b1 || bus.w_sprite_y_height_en !== 1'b0)
          $display("FAIL host_mirror idx=%0d x=%h en_x=%b en_y=%b, want idx=%0d x=%h en_x=1 en_y=0",
                   bus.w_index, bus.w_sprite_x_width, bus.w_sprite_x_width_en,
                   bus.w_sprite_y_height_en, ev_idx, ev_val);
        else pass_cnt++;
      end else begin
        bus.h_x_width_en = 1'b0;
      end
      @(negedge clk_draw);
    end
    bus.start = 1'b0;
    bus.h_x_width_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_draw);
    check_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_flags busy=%b done=%b, want 0 0", bus.busy, bus.done);
    else pass_cnt++;
    check_cnt++;
    if (bus.sprite_index !== 9'd0) $display("FAIL reset_index got %0d want 0", bus.sprite_index);
    else pass_cnt++;
    check_cnt++;
    if ({bus.w_sprite_y_height_en, bus.w_sprite_x_width_en, bus.w_sprite_addr_en, bus.w_sprite_velocity_en} !== 4'b0000)
      $display("FAIL reset_enables got %b want 0000",
               {bus.w_sprite_y_height_en, bus.w_sprite_x_width_en, bus.w_sprite_addr_en, bus.w_sprite_velocity_en});
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk_draw);
  endtask

  task automatic test_basic_scan();
    int lat, e0;
    gen_random();
    init_y[0] = {4'h0, 8'd1, 8'h00, 12'd50, 4'd0};
    init_x[0] = {4'h0, 8'd1, 8'h00, 12'd100, 4'd0};
    init_v[0] = {18'd16, 18'd0};
    init_y[1] = {4'h0, 8'd1, 8'h00, 12'd100, 4'd0};
    init_x[1] = {4'h0, 8'd1, 8'h00, 12'd0, 4'd1};
    init_v[1] = {18'h3ffe0, 18'd0};
    init_y[2] = {4'h0, 8'd1, 8'h00, 12'd50, 4'd0};
    init_x[2] = {4'h0, 8'd1, 8'h00, 12'd1262, 4'd0};
    init_v[2] = {18'd48, 18'd0};
    init_y[3] = {4'h0, 8'd1, 8'h00, 12'd0, 4'd0};
    init_x[3] = {4'h0, 8'd1, 8'h00, 12'd100, 4'd0};
    init_v[3] = {18'd0, 18'h20000};
    load_all();
    model_all();
    run_scan(-1, 9'd0, 36'd0, -1, lat, e0);
    check_cnt++;
    if (lat !== 3 * N + 1) $display("FAIL basic_latency got %0d want %0d", lat, 3 * N + 1);
    else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      check_cnt++;
      if (mem_y[i] !== exp_y[i] || mem_x[i] !== exp_x[i] || mem_v[i] !== exp_v[i] ||
          seen_ve[i] !== exp_ve[i] || seen_xy[i] !== exp_wr[i])
        $display("FAIL basic_sprite[%0d] y=%h x=%h v=%h ve=%b, want y=%h x=%h v=%h ve=%b",
                 i, mem_y[i], mem_x[i], mem_v[i], seen_ve[i], exp_y[i], exp_x[i], exp_v[i], exp_ve[i]);
      else pass_cnt++;
    end
    check_cnt++;
    if (mem_x[0][15:4] !== 12'd101 || seen_ve[0] !== 1'b0)
      $display("FAIL step_right screen_x=%0d ve=%b, want 101 0", mem_x[0][15:4], seen_ve[0]);
    else pass_cnt++;
    check_cnt++;
    if (mem_x[1][15:0] !== 16'd0 || mem_v[1][35:18] !== 18'd32 || seen_ve[1] !== 1'b1)
      $display("FAIL bounce_left pos=%h vx=%h ve=%b, want 0000 00020 1", mem_x[1][15:0], mem_v[1][35:18], seen_ve[1]);
    else pass_cnt++;
    check_cnt++;
    if (mem_x[2][15:0] !== 16'd20224 || mem_v[2][35:18] !== 18'h3ffd0)
      $display("FAIL bounce_right pos=%0d vx=%h, want 20224 3ffd0", mem_x[2][15:0], mem_v[2][35:18]);
    else pass_cnt++;
    check_cnt++;
    if (mem_y[3][15:0] !== 16'd0 || mem_v[3][17:0] !== 18'h1ffff)
      $display("FAIL vel_saturate pos=%h vy=%h, want 0000 1ffff", mem_y[3][15:0], mem_v[3][17:0]);
    else pass_cnt++;
    check_cnt++;
    if (addr_en_cnt !== 0) $display("FAIL addr_en_never got %0d want 0", addr_en_cnt);
    else pass_cnt++;
  endtask

  task automatic test_restart_ignored();
    int lat, e0, extra;
    run_scan(-1, 9'd0, 36'd0, 10, lat, e0);
    check_cnt++;
    if (lat !== 3 * N + 1) $display("FAIL restart_latency got %0d want %0d", lat, 3 * N + 1);
    else pass_cnt++;
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_draw);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    check_cnt++;
    if (extra !== 0) $display("FAIL restart_extra_activity got %0d want 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_hazard_cancel();
    int lat, e0;
    logic [35:0] hv;
    gen_random();
    load_all();
    model_all();
    hv = {4'h5, 8'd2, 8'h3c, 12'd640, 4'd7};
    exp_x[5] = hv;
    exp_y[5] = init_y[5];
    exp_v[5] = init_v[5];
    exp_ve[5] = 1'b0;
    exp_wr[5] = 1'b0;
    run_scan(16, 9'd5, hv, -1, lat, e0);
    check_cnt++;
    if (lat !== 3 * N + 1) $display("FAIL cancel_latency got %0d want %0d", lat, 3 * N + 1);
    else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      check_cnt++;
      if (mem_y[i] !== exp_y[i] || mem_x[i] !== exp_x[i] || mem_v[i] !== exp_v[i] ||
          seen_ve[i] !== exp_ve[i] || seen_xy[i] !== exp_wr[i])
        $display("FAIL cancel_sprite[%0d] y=%h x=%h v=%h wr=%b, want y=%h x=%h v=%h wr=%b",
                 i, mem_y[i], mem_x[i], mem_v[i], seen_xy[i], exp_y[i], exp_x[i], exp_v[i], exp_wr[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_hazard_stall();
    int lat, e0;
    logic [35:0] hv;
    bit be;
    gen_random();
    load_all();
    hv = {4'ha, 8'd1, 8'h11, 12'd1270, 4'd3};
    init_x[9] = hv;
    model_all();
    run_scan(17, 9'd9, hv, -1, lat, e0);
    check_cnt++;
    if (lat !== 3 * N + 2) $display("FAIL stall_latency got %0d want %0d", lat, 3 * N + 2);
    else pass_cnt++;
    check_cnt++;
    if (wr5_edge - e0 !== 18) $display("FAIL stall_write_cycle got %0d want 18", wr5_edge - e0);
    else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      check_cnt++;
      if (mem_y[i] !== exp_y[i] || mem_x[i] !== exp_x[i] || mem_v[i] !== exp_v[i] || seen_ve[i] !== exp_ve[i])
        $display("FAIL stall_sprite[%0d] y=%h x=%h v=%h, want y=%h x=%h v=%h",
                 i, mem_y[i], mem_x[i], mem_v[i], exp_y[i], exp_x[i], exp_v[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_scan();
    int snap, active;
    @(negedge clk_draw);
    bus.start = 1'b1;
    @(negedge clk_draw);
    bus.start = 1'b0;
    repeat (600) @(negedge clk_draw);
    check_cnt++;
    if (bus.sprite_index !== 9'd200 || bus.busy !== 1'b1)
      $display("FAIL midscan_position index=%0d busy=%b, want 200 1", bus.sprite_index, bus.busy);
    else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk_draw);
    check_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sprite_index !== 9'd0)
      $display("FAIL midscan_reset busy=%b done=%b index=%0d, want 0 0 0", bus.busy, bus.done, bus.sprite_index);
    else pass_cnt++;
    snap = seq_en_cnt;
    rst_n = 1'b1;
    active = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_draw);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) active++;
    end
    check_cnt++;
    if (seq_en_cnt !== snap || active !== 0)
      $display("FAIL midscan_quiet writes=%0d active=%0d, want 0 0", seq_en_cnt - snap, active);
    else pass_cnt++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.h_index = 9'd0;
    bus.h_y_height = 36'd0;
    bus.h_x_width = 36'd0;
    bus.h_addr = 36'd0;
    bus.h_velocity = 36'd0;
    bus.h_y_height_en = 1'b0;
    bus.h_x_width_en = 1'b0;
    bus.h_addr_en = 1'b0;
    bus.h_velocity_en = 1'b0;
    clr_req = 1'b1;
    pass_cnt = 0;
    check_cnt = 0;
    test_reset();
    clr_req = 1'b0;
    test_basic_scan();
    test_restart_ignored();
    test_hazard_cancel();
    test_hazard_stall();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/sprite_motion_sequencer.md
Name: sprite_motion_sequencer

Overview:
Per-frame motion engine for the sprite attribute BRAM. On each start pulse (vblank) it walks sprites 0..NUM_SPRITES-1. For each sprite it reads the y_height, x_width and velocity words, adds velocity to the sub-pixel position, bounces off the screen bounds, and writes the results back. It also owns the BRAM write port, arbitrating between host (CPU/loader) writes and its own writeback.

Parameters:
NUM_SPRITES, 512, sprites scanned per frame (power of two, ≤512)
TILE_PX, 16, pixels per tile; sprite extent = width*TILE_PX, height*TILE_PX
X_MIN, 0, leftmost legal screen_x (pixels)
X_MAX, 1280, exclusive right bound (pixels)
Y_MIN, 0, top legal screen_y
Y_MAX, 720, exclusive bottom bound

Ports:
clk_draw  in  1  draw clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse: begin a scan
busy  out  1  scan in progress
done  out  1  one-cycle pulse after last writeback
sprite_index  out  9  BRAM read index
sprite_y_height  in  36  BRAM read data (1-cycle latency)
sprite_x_width  in  36  BRAM read data
sprite_velocity  in  36  BRAM read data
h_index  in  9  host write index
h_y_height / h_x_width / h_addr / h_velocity  in  36 each  host write data
h_y_height_en / h_x_width_en / h_addr_en / h_velocity_en  in  1 each  host field write enables
w_index  out  9  BRAM write index
w_sprite_y_height / w_sprite_x_width / w_sprite_addr / w_sprite_velocity  out  36 each  BRAM write data
w_sprite_y_height_en / w_sprite_x_width_en / w_sprite_addr_en / w_sprite_velocity_en  out  1 each  BRAM write enables

Behaviour:
- Field layout:
  - y_height: [3:0] sub_y, [15:4] screen_y, [31:24] height.
  - x_width: [3:0] sub_x, [15:4] screen_x, [31:24] width.
  - velocity: [17:0] vel_y, [35:18] vel_x; each is 18-bit two's complement in 1/16 px per frame.
  - All other bits pass through unchanged.
- Reset: state IDLE, counter 0, busy=0, done=0, sprite_index=0, all w_*_en=0. Reset mid-scan abandons the scan; no further writes.
- FSM is IDLE → RD → CALC → WR → (RD | FIN) → IDLE, at 3 cycles per sprite.
  - IDLE: start → RD, busy=1. start while busy is ignored.
  - RD: sprite_index=cnt; BRAM samples it.
  - CALC: read data valid. Compute and register new x, y and velocity.
  - WR: write back unless cancelled or stalled. Then cnt+1; last sprite → FIN.
  - FIN: done=1 for one cycle, busy=0, cnt=0 → IDLE.
- Per axis, with p = {screen, sub} (16-bit unsigned) and v the signed velocity:
  - s = zero-ext(p) + sign-ext(v), computed in 20-bit signed.
  - ext = size*TILE_PX*16; lo = MIN*16; hi = MAX*16.
  - If s < lo: p' = lo, v' = -v.
  - Else if s + ext > hi: p' = hi - ext, v' = -v.
  - Else: p' = s, v' = v.
  - -v of -131072 saturates to +131071. An extent ≥ range clamps p' to lo.
- Writeback: y_height_en and x_width_en are always asserted. velocity_en is asserted only if either axis bounced. addr_en is never asserted by the sequencer.
- Arbitration:
  - Any h_*_en high → w_* mirror the host inputs combinationally that cycle (host priority).
  - If the sequencer is in WR and the host is writing, the sequencer holds WR (stall) until the host is idle.
- Hazard: a host write with h_index == cnt in RD, CALC or WR cancels this sprite's writeback. WR then completes with no enables asserted, and the host data stands.
- Full scan with no host traffic: done asserts exactly 3*NUM_SPRITES+1 cycles after start.

Test Plan:
1. Sprite 0: screen_x=100, sub 0, vel_x=+16, vel_y=0; start → x_width writeback has screen_x=101; velocity_en=0 for sprite 0.
2. screen_x=0, sub 1, vel_x=-32 → screen_x=0, sub 0 (clamped to X_MIN); vel_x=+32; velocity_en=1.
3. width=1, screen_x=1262, vel_x=+48 → s+256 > 20480, so screen_x=1264, sub 0; vel_x=-48.
4. vel_y=-131072 at screen_y=0 → screen_y=0; vel_y=+131071 (saturated).
5. Host writes x_width to index 5 during sprite 5's CALC → no sequencer enables for index 5; BRAM keeps host value. A host write to index 9 during sprite 5's WR → sequencer stalls exactly one cycle, then writes.
6. Start, no host traffic → done at start+1537 with NUM_SPRITES=512. A second start while busy is ignored. rst_n low at sprite 200 → busy=0 and no further enables.
